// File: rtl/bpu_pkg.sv
// Shared types and helpers for the fetch-side branch prediction unit.
// Optional feature macro: BPU_GSHARE_EN (see branch_predictor.sv).
package bpu_pkg;

    localparam int DEF_PHT_IDX_W = 5;
    localparam int DEF_BTB_IDX_W = 4;

    // 2-bit saturating direction counter
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    // Tag is kept 32 bits wide (upper PC bits shifted down, zero-extended)
    // so the struct does not depend on the BTB index width.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
    } btb_entry_t;

    // Move a counter one step toward the observed outcome, clamping at the ends.
    function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
        ctr_t next_ctr;
        case (ctr)
            SNT:     next_ctr = taken ? WNT : SNT;
            WNT:     next_ctr = taken ? WT  : SNT;
            WT:      next_ctr = taken ? ST  : WNT;
            ST:      next_ctr = taken ? ST  : WT;
            default: next_ctr = WNT;
        endcase
        return next_ctr;
    endfunction

endpackage

// File: rtl/sat_counter_array.sv
// Pattern history table: array of 2-bit saturating counters with one
// combinational read port and one trained write port.
module sat_counter_array
    import bpu_pkg::*;
#(
    parameter int IDX_W = DEF_PHT_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_rst,
    input  logic [IDX_W-1:0] rd_idx,
    output ctr_t             rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int DEPTH = 1 << IDX_W;

    ctr_t ctr_r [DEPTH];

    // Counter storage: clear to weakly not-taken, otherwise train on resolution
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_r[i] <= WNT;
            end
        end else if (!d_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_r[i] <= WNT;
            end
        end else if (wr_en) begin
            ctr_r[wr_idx] <= sat_update(ctr_r[wr_idx], wr_taken);
        end
    end

    // Read returns the pre-update value; a same-cycle write shows up next cycle.
    assign rd_ctr = ctr_r[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: 2-bit counter PHT plus direct-mapped BTB,
// zero-cycle lookup on F_PC, non-speculative training from EX.
// Optional feature macro: BPU_GSHARE_EN -- when defined the PHT index is
// PC bits XOR a global history register; otherwise plain bimodal indexing.
module branch_predictor
    import bpu_pkg::*;
#(
    parameter int PHT_IDX_W = DEF_PHT_IDX_W,
    parameter int BTB_IDX_W = DEF_BTB_IDX_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 d_rst,
    input  logic [31:0]          F_PC,
    output logic                 F_pred_taken,
    output logic [PHT_IDX_W-1:0] F_pht_idx,
    output logic                 F_btb_hit,
    output logic [31:0]          F_btb_target,
    output logic [31:0]          F_pred_pc,
    input  logic                 E_br_valid,
    input  logic                 E_is_cond,
    input  logic                 E_taken,
    input  logic [31:0]          E_PC,
    input  logic [31:0]          E_target,
    input  logic [PHT_IDX_W-1:0] E_pht_idx
);

    localparam int BTB_DEPTH = 1 << BTB_IDX_W;
    localparam int TAG_LSB   = BTB_IDX_W + 2;

    btb_entry_t           btb_r [BTB_DEPTH];
    btb_entry_t           lookup_entry_s;
    logic [BTB_IDX_W-1:0] f_btb_idx_s;
    logic [BTB_IDX_W-1:0] e_btb_idx_s;
    logic [31:0]          f_tag_s;
    logic [31:0]          e_tag_s;
    logic [PHT_IDX_W-1:0] pht_idx_s;
    ctr_t                 lookup_ctr_s;
    logic                 pht_wr_en_s;

    assign f_btb_idx_s = F_PC[BTB_IDX_W+1:2];
    assign e_btb_idx_s = E_PC[BTB_IDX_W+1:2];
    assign f_tag_s     = F_PC >> TAG_LSB;
    assign e_tag_s     = E_PC >> TAG_LSB;
    assign pht_wr_en_s = E_br_valid & E_is_cond;

`ifdef BPU_GSHARE_EN
    logic [PHT_IDX_W-1:0] ghr_r;

    // Global history: shift in each resolved conditional outcome
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_r <= {PHT_IDX_W{1'b0}};
        end else if (!d_rst) begin
            ghr_r <= {PHT_IDX_W{1'b0}};
        end else if (pht_wr_en_s) begin
            ghr_r <= {ghr_r[PHT_IDX_W-2:0], E_taken};
        end
    end

    assign pht_idx_s = F_PC[PHT_IDX_W+1:2] ^ ghr_r;
`else
    assign pht_idx_s = F_PC[PHT_IDX_W+1:2];
`endif

    assign F_pht_idx = pht_idx_s;

    sat_counter_array #(
        .IDX_W (PHT_IDX_W)
    ) u_pht (
        .clk      (clk),
        .rst      (rst),
        .d_rst    (d_rst),
        .rd_idx   (pht_idx_s),
        .rd_ctr   (lookup_ctr_s),
        .wr_en    (pht_wr_en_s),
        .wr_idx   (E_pht_idx),
        .wr_taken (E_taken)
    );

    // BTB: only valid bits are cleared; any taken transfer installs/overwrites
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_r[i].valid <= 1'b0;
            end
        end else if (!d_rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_r[i].valid <= 1'b0;
            end
        end else if (E_br_valid && E_taken) begin
            btb_r[e_btb_idx_s] <= '{valid: 1'b1, tag: e_tag_s, target: E_target};
        end
    end

    // Combinational lookup: BTB hit, stored target and next-PC selection
    always_comb begin
        lookup_entry_s = btb_r[f_btb_idx_s];
        F_btb_hit      = lookup_entry_s.valid && (lookup_entry_s.tag == f_tag_s);
        if (F_btb_hit) begin
            F_btb_target = lookup_entry_s.target;
        end else begin
            F_btb_target = 32'd0;
        end
        F_pred_taken = F_btb_hit && ((lookup_ctr_s == WT) || (lookup_ctr_s == ST));
        if (F_pred_taken) begin
            F_pred_pc = F_btb_target;
        end else begin
            F_pred_pc = F_PC + 32'd4;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (bimodal or gshare build).
module tb_branch_predictor;

    localparam int PW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          d_rst;
    logic [31:0]   F_PC;
    logic          F_pred_taken;
    logic [PW-1:0] F_pht_idx;
    logic          F_btb_hit;
    logic [31:0]   F_btb_target;
    logic [31:0]   F_pred_pc;
    logic          E_br_valid;
    logic          E_is_cond;
    logic          E_taken;
    logic [31:0]   E_PC;
    logic [31:0]   E_target;
    logic [PW-1:0] E_pht_idx;

    int checks = 0;
    int errors = 0;

    // Reference state: counters and global history as the bench expects them
    logic [1:0]    pht_m [32];
    logic [PW-1:0] ghr_m;

    branch_predictor dut (
        .clk          (clk),
        .rst          (rst),
        .d_rst        (d_rst),
        .F_PC         (F_PC),
        .F_pred_taken (F_pred_taken),
        .F_pht_idx    (F_pht_idx),
        .F_btb_hit    (F_btb_hit),
        .F_btb_target (F_btb_target),
        .F_pred_pc    (F_pred_pc),
        .E_br_valid   (E_br_valid),
        .E_is_cond    (E_is_cond),
        .E_taken      (E_taken),
        .E_PC         (E_PC),
        .E_target     (E_target),
        .E_pht_idx    (E_pht_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] exp_idx(input logic [31:0] pc);
        return pc[PW+1:2] ^ ghr_m;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) pht_m[i] = 2'b01;
        ghr_m = '0;
    endtask

    task automatic model_train(input logic is_cond, input logic taken, input logic [PW-1:0] idx);
        if (is_cond) begin
            if (taken && pht_m[idx] != 2'b11) pht_m[idx] = pht_m[idx] + 2'd1;
            else if (!taken && pht_m[idx] != 2'b00) pht_m[idx] = pht_m[idx] - 2'd1;
`ifdef BPU_GSHARE_EN
            ghr_m = {ghr_m[PW-2:0], taken};
`endif
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic train(input logic is_cond, input logic taken,
                         input logic [31:0] pc, input logic [31:0] tgt);
        logic [PW-1:0] idx;
        idx = exp_idx(pc);
        @(negedge clk);
        E_br_valid = 1'b1; E_is_cond = is_cond; E_taken = taken;
        E_PC = pc; E_target = tgt; E_pht_idx = idx;
        @(posedge clk);
        model_train(is_cond, taken, idx);
        #1;
        E_br_valid = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        @(negedge clk);
        F_PC = pc;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] pred_exp;
        rst = 1'b1; d_rst = 1'b1; F_PC = 32'h100;
        E_br_valid = 1'b0; E_is_cond = 1'b0; E_taken = 1'b0;
        E_PC = 32'd0; E_target = 32'd0; E_pht_idx = '0;
        model_clear();
        #1;
        checks++; if (F_btb_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b want 0", F_btb_hit); end
        checks++; if (F_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred got %b want 0", F_pred_taken); end
        checks++; if (F_btb_target !== 32'd0) begin errors++; $display("FAIL reset_target got %h want 0", F_btb_target); end
        checks++; if (F_pred_pc !== 32'h104) begin errors++; $display("FAIL reset_pred_pc got %h want 104", F_pred_pc); end
        checks++; if (F_pht_idx !== exp_idx(32'h100)) begin errors++; $display("FAIL reset_idx got %h want %h", F_pht_idx, exp_idx(32'h100)); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        // Probe a counter: 01 -> taken -> 10 (predict taken) -> not-taken -> 01
        train(1'b1, 1'b1, 32'h100, 32'h180);
        look(32'h100);
        checks++; if (F_btb_hit !== 1'b1 || F_btb_target !== 32'h180) begin errors++; $display("FAIL probe_btb got hit=%b tgt=%h want 1 180", F_btb_hit, F_btb_target); end
        checks++; if (F_pred_taken !== pht_m[exp_idx(32'h100)][1]) begin errors++; $display("FAIL probe_weak_taken got %b want %b", F_pred_taken, pht_m[exp_idx(32'h100)][1]); end
        train(1'b1, 1'b0, 32'h100, 32'h180);
        look(32'h100);
        pred_exp = pht_m[exp_idx(32'h100)][1] ? 32'h180 : 32'h104;
        checks++; if (F_pred_pc !== pred_exp) begin errors++; $display("FAIL probe_back_weak got %h want %h", F_pred_pc, pred_exp); end
    endtask

    task automatic test_train_taken();
        logic [31:0] pred_exp;
        do_reset();
        train(1'b1, 1'b1, 32'h200, 32'h280);
        train(1'b1, 1'b1, 32'h200, 32'h280);
        look(32'h200);
        pred_exp = pht_m[exp_idx(32'h200)][1] ? 32'h280 : 32'h204;
        checks++; if (F_btb_hit !== 1'b1) begin errors++; $display("FAIL train_hit got %b want 1", F_btb_hit); end
        checks++; if (F_btb_target !== 32'h280) begin errors++; $display("FAIL train_target got %h want 280", F_btb_target); end
        checks++; if (F_pht_idx !== exp_idx(32'h200)) begin errors++; $display("FAIL train_idx got %h want %h", F_pht_idx, exp_idx(32'h200)); end
        checks++; if (F_pred_pc !== pred_exp) begin errors++; $display("FAIL train_pred_pc got %h want %h", F_pred_pc, pred_exp); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) train(1'b1, 1'b1, 32'h200, 32'h280);
        look(32'h200);
        checks++; if (F_pred_taken !== pht_m[exp_idx(32'h200)][1]) begin errors++; $display("FAIL sat_high got %b want %b", F_pred_taken, pht_m[exp_idx(32'h200)][1]); end
        for (int i = 0; i < 4; i++) begin
            train(1'b1, 1'b0, 32'h200, 32'h280);
            look(32'h200);
            checks++; if (F_pred_taken !== pht_m[exp_idx(32'h200)][1]) begin errors++; $display("FAIL sat_dec%0d got %b want %b", i, F_pred_taken, pht_m[exp_idx(32'h200)][1]); end
        end
        checks++; if (F_btb_hit !== 1'b1) begin errors++; $display("FAIL sat_hit_kept got %b want 1", F_btb_hit); end
    endtask

    task automatic test_btb_alias();
        logic [31:0] pred_exp;
        train(1'b1, 1'b1, 32'h240, 32'h300);
        look(32'h200);
        checks++; if (F_btb_hit !== 1'b0 || F_pred_pc !== 32'h204) begin errors++; $display("FAIL alias_old got hit=%b pc=%h want 0 204", F_btb_hit, F_pred_pc); end
        look(32'h240);
        pred_exp = pht_m[exp_idx(32'h240)][1] ? 32'h300 : 32'h244;
        checks++; if (F_btb_hit !== 1'b1 || F_btb_target !== 32'h300) begin errors++; $display("FAIL alias_new got hit=%b tgt=%h want 1 300", F_btb_hit, F_btb_target); end
        checks++; if (F_pred_pc !== pred_exp) begin errors++; $display("FAIL alias_pred_pc got %h want %h", F_pred_pc, pred_exp); end
    endtask

    task automatic test_same_cycle();
        logic [PW-1:0] idx;
        logic [31:0]   pred_exp;
        idx = exp_idx(32'h48);
        @(negedge clk);
        F_PC = 32'h48;
        E_br_valid = 1'b1; E_is_cond = 1'b1; E_taken = 1'b1;
        E_PC = 32'h48; E_target = 32'h500; E_pht_idx = idx;
        #1;
        checks++; if (F_btb_hit !== 1'b0 || F_pred_pc !== 32'h4c) begin errors++; $display("FAIL same_old got hit=%b pc=%h want 0 4c", F_btb_hit, F_pred_pc); end
        @(posedge clk);
        model_train(1'b1, 1'b1, idx);
        #1;
        E_br_valid = 1'b0;
        #1;
        pred_exp = pht_m[exp_idx(32'h48)][1] ? 32'h500 : 32'h4c;
        checks++; if (F_btb_hit !== 1'b1 || F_btb_target !== 32'h500) begin errors++; $display("FAIL same_new got hit=%b tgt=%h want 1 500", F_btb_hit, F_btb_target); end
        checks++; if (F_pred_pc !== pred_exp) begin errors++; $display("FAIL same_new_pc got %h want %h", F_pred_pc, pred_exp); end
    endtask

    task automatic test_soft_clear();
        logic [31:0] pred_exp;
        @(negedge clk);
        d_rst = 1'b0;
        @(negedge clk);
        d_rst = 1'b1;
        model_clear();
        look(32'h240);
        checks++; if (F_btb_hit !== 1'b0 || F_pred_pc !== 32'h244) begin errors++; $display("FAIL soft_btb240 got hit=%b pc=%h want 0 244", F_btb_hit, F_pred_pc); end
        look(32'h48);
        checks++; if (F_btb_hit !== 1'b0) begin errors++; $display("FAIL soft_btb48 got %b want 0", F_btb_hit); end
        checks++; if (F_pht_idx !== exp_idx(32'h48)) begin errors++; $display("FAIL soft_idx got %h want %h", F_pht_idx, exp_idx(32'h48)); end
        // Counter at 0x48 was 10 before the clear; 01 after one taken+one not-taken stays not-taken
        train(1'b1, 1'b1, 32'h48, 32'h500);
        train(1'b1, 1'b0, 32'h48, 32'h500);
        look(32'h48);
        pred_exp = pht_m[exp_idx(32'h48)][1] ? 32'h500 : 32'h4c;
        checks++; if (F_pred_pc !== pred_exp) begin errors++; $display("FAIL soft_ctr got %h want %h", F_pred_pc, pred_exp); end
    endtask

    task automatic test_jump();
        train(1'b0, 1'b1, 32'h60, 32'h700);
        look(32'h60);
        checks++; if (F_btb_hit !== 1'b1 || F_btb_target !== 32'h700) begin errors++; $display("FAIL jump_btb got hit=%b tgt=%h want 1 700", F_btb_hit, F_btb_target); end
        checks++; if (F_pht_idx !== exp_idx(32'h60)) begin errors++; $display("FAIL jump_idx got %h want %h", F_pht_idx, exp_idx(32'h60)); end
        checks++; if (F_pred_pc !== 32'h64) begin errors++; $display("FAIL jump_pht_kept got %h want 64", F_pred_pc); end
    endtask

    task automatic test_wrap();
        look(32'hFFFF_FFFC);
        checks++; if (F_btb_hit !== 1'b0 || F_pred_pc !== 32'h0) begin errors++; $display("FAIL wrap got hit=%b pc=%h want 0 0", F_btb_hit, F_pred_pc); end
    endtask

    initial begin
        test_reset();
        test_train_taken();
        test_saturation();
        test_btb_alias();
        test_same_cycle();
        test_soft_clear();
        test_jump();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
